// File: rtl/adder_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg
//   Shared elaboration helpers for the pipelined adder slice.
//   - seg_width : carry-chain segment width handled by one pipeline stage
//   - cfg_ok    : legality of a WIDTH/STAGES pair (both >= 1, WIDTH divisible
//                 by STAGES); used by an elaboration-time check in the top
// -----------------------------------------------------------------------------
package adder_pkg;

    function automatic int seg_width(input int width, input int stages);
        return width / stages;
    endfunction

    function automatic bit cfg_ok(input int width, input int stages);
        return (width >= 1) && (stages >= 1) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/adder_segment.sv
// -----------------------------------------------------------------------------
// adder_segment
//   One SEG-bit combinational full-adder slice of the carry chain.
//   Ports:
//     a, b  [SEG-1:0]  operand bits of this segment
//     cin              carry into the segment
//     sum   [SEG-1:0]  segment sum bits
//     cout             carry out of the segment MSB
// -----------------------------------------------------------------------------
module adder_segment
    import adder_pkg::*;
#(
    parameter int SEG = 4
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] sum,
    output logic           cout
);

    // One extra bit holds the carry out of the segment.
    logic [SEG:0] total;

    assign total = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, cin};
    assign sum   = total[SEG-1:0];
    assign cout  = total[SEG];

endmodule

// File: rtl/pipelined_adder.sv
// -----------------------------------------------------------------------------
// pipelined_adder
//   WIDTH-bit unsigned adder with carry-in/carry-out whose carry chain is cut
//   into STAGES registered segments of SEG = WIDTH/STAGES bits. Each stage
//   adds one segment and passes the remaining operand bits plus its carry to
//   the next stage. Valid/ready handshake on both sides; empty stages always
//   accept, so gaps in the input stream collapse. Latency STAGES cycles,
//   throughput one beat per cycle.
//
//   Ports:
//     clk        clock, rising edge
//     reset      asynchronous, active-low reset
//     in_valid   operand beat valid
//     in_ready   block accepts a beat this cycle (combinational from out_ready)
//     in_a/in_b  [WIDTH-1:0] unsigned operands
//     in_cin     carry-in
//     out_valid  result beat valid
//     out_ready  consumer accepts the result
//     out_sum    [WIDTH-1:0] sum
//     out_cout   carry-out of the MSB
//
//   Optional build macro PIPELINED_ADDER_SATURATE_EN: when defined, a final
//   carry of 1 forces out_sum to all ones (out_cout stays 1). The clamp sits
//   after the last stage register, so latency is unchanged.
// -----------------------------------------------------------------------------
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout
);

    localparam int SEG = seg_width(WIDTH, STAGES);

    if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg_check
        $error("pipelined_adder: WIDTH must be >= 1 and divisible by STAGES >= 1");
    end

    // Per-stage payload. sum fills from the top: each stage shifts the
    // previous partial sum down by SEG and inserts its segment at the MSBs,
    // so after STAGES stages the sum is aligned. a_hi/b_hi are shifted the
    // same way so the next segment's operands are always at bits [SEG-1:0].
    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic [WIDTH-1:0] a_hi;
        logic [WIDTH-1:0] b_hi;
        logic             carry;
    } stage_t;

    logic [STAGES-1:0] valid_reg;
    stage_t            stage_reg  [STAGES];
    stage_t            stage_next [STAGES];
    logic [STAGES:0]   ready;

    // Ready ripples backwards from the consumer; a stage can take a beat if
    // it is empty or its own content is leaving this cycle.
    always_comb begin
        ready         = '0;
        ready[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            ready[k] = !valid_reg[k] || ready[k+1];
        end
    end

    assign in_ready = ready[0];

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        logic             up_valid;
        logic [WIDTH-1:0] up_sum;
        logic [WIDTH-1:0] up_a;
        logic [WIDTH-1:0] up_b;
        logic             up_carry;
        logic [SEG-1:0]   seg_sum;
        logic             seg_cout;
        logic [WIDTH+SEG-1:0] sum_cat;

        if (gi == 0) begin : g_first
            assign up_valid = in_valid;
            assign up_sum   = '0;
            assign up_a     = in_a;
            assign up_b     = in_b;
            assign up_carry = in_cin;
        end else begin : g_rest
            assign up_valid = valid_reg[gi-1];
            assign up_sum   = stage_reg[gi-1].sum;
            assign up_a     = stage_reg[gi-1].a_hi;
            assign up_b     = stage_reg[gi-1].b_hi;
            assign up_carry = stage_reg[gi-1].carry;
        end

        adder_segment #(.SEG(SEG)) u_segment (
            .a    (up_a[SEG-1:0]),
            .b    (up_b[SEG-1:0]),
            .cin  (up_carry),
            .sum  (seg_sum),
            .cout (seg_cout)
        );

        assign sum_cat = {seg_sum, up_sum};

        assign stage_next[gi] = '{
            sum:   sum_cat[WIDTH+SEG-1:SEG],
            a_hi:  up_a >> SEG,
            b_hi:  up_b >> SEG,
            carry: seg_cout
        };

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                valid_reg[gi] <= 1'b0;
                stage_reg[gi] <= '0;
            end else if (ready[gi]) begin
                valid_reg[gi] <= up_valid;
                // Data only moves with a real beat so idle stages stay quiet.
                if (up_valid) begin
                    stage_reg[gi] <= stage_next[gi];
                end
            end
        end
    end

    assign out_valid = valid_reg[STAGES-1];
    assign out_cout  = stage_reg[STAGES-1].carry;

`ifdef PIPELINED_ADDER_SATURATE_EN
    assign out_sum = stage_reg[STAGES-1].carry ? {WIDTH{1'b1}} : stage_reg[STAGES-1].sum;
`else
    assign out_sum = stage_reg[STAGES-1].sum;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// -----------------------------------------------------------------------------
// tb_pipelined_adder
//   Directed and randomised checks of pipelined_adder at WIDTH=8, STAGES=2.
//   Inputs change 1 time unit after the rising edge; outputs are sampled on
//   the falling edge.
// -----------------------------------------------------------------------------
module tb_pipelined_adder;

    localparam int WIDTH  = 8;
    localparam int STAGES = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipelined_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout)
    );

    // Reference result {cout, sum}, including the optional clamp.
    function automatic logic [WIDTH:0] ref_add(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic cin);
        logic [WIDTH:0] full;
        full = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
`ifdef PIPELINED_ADDER_SATURATE_EN
        if (full[WIDTH]) full[WIDTH-1:0] = '1;
`endif
        return full;
    endfunction

    // Sends one beat into an empty pipeline with out_ready=1 and returns the
    // result and the latency in cycles (lat=0 when nothing came out).
    task automatic run_single(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                              input logic cin, output logic [WIDTH-1:0] s,
                              output logic c, output int lat);
        bit accepted;
        s = '0; c = 1'b0; lat = 0; accepted = 0;
        in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
        for (int i = 0; i < 10 && !accepted; i++) begin
            @(negedge clk);
            accepted = in_ready;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (accepted) begin
            for (int i = 1; i <= 10; i++) begin
                @(negedge clk);
                if (out_valid) begin
                    s = out_sum; c = out_cout; lat = i;
                    break;
                end
                @(posedge clk); #1;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
        checks++; if (out_sum !== 8'h00) begin failures++; $display("FAIL reset_out_sum got=%02h exp=00", out_sum); end
        checks++; if (out_cout !== 1'b0) begin failures++; $display("FAIL reset_out_cout got=%0b exp=0", out_cout); end
        @(posedge clk); #3; reset = 1'b1;
        @(posedge clk); #1;
        $display("test_reset done");
    endtask

    task automatic test_basic();
        logic [WIDTH-1:0] s; logic c; int lat;
        run_single(8'h12, 8'h34, 1'b0, s, c, lat);
        checks++; if (lat !== STAGES) begin failures++; $display("FAIL basic_latency got=%0d exp=%0d", lat, STAGES); end
        checks++; if (s !== 8'h46) begin failures++; $display("FAIL basic_sum got=%02h exp=46", s); end
        checks++; if (c !== 1'b0) begin failures++; $display("FAIL basic_cout got=%0b exp=0", c); end
        $display("test_basic 12+34+0 -> sum=%02h cout=%0b lat=%0d", s, c, lat);
    endtask

    task automatic test_overflow();
        logic [WIDTH-1:0] s; logic c; int lat;
        logic [WIDTH-1:0] exp_s;
`ifdef PIPELINED_ADDER_SATURATE_EN
        exp_s = 8'hFF;
`else
        exp_s = 8'h00;
`endif
        run_single(8'hFF, 8'h01, 1'b0, s, c, lat);
        checks++; if (s !== exp_s) begin failures++; $display("FAIL overflow_sum got=%02h exp=%02h", s, exp_s); end
        checks++; if (c !== 1'b1) begin failures++; $display("FAIL overflow_cout got=%0b exp=1", c); end
        $display("test_overflow FF+01+0 -> sum=%02h cout=%0b", s, c);
    endtask

    task automatic test_carry_in();
        logic [WIDTH-1:0] s; logic c; int lat;
        run_single(8'h0F, 8'h00, 1'b1, s, c, lat);
        checks++; if (s !== 8'h10) begin failures++; $display("FAIL carry_in_sum got=%02h exp=10", s); end
        checks++; if (c !== 1'b0) begin failures++; $display("FAIL carry_in_cout got=%0b exp=0", c); end
        $display("test_carry_in 0F+00+1 -> sum=%02h cout=%0b", s, c);
    endtask

    task automatic test_backpressure();
        int next_beat = 1;
        int accepts = 0;
        int unstable = 0;
        int n_out = 0;
        logic [WIDTH-1:0] got [4];
        int got_cyc [4];
        bit acc;
        logic [WIDTH-1:0] exp_v;

        out_ready = 1'b0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            in_valid = (next_beat <= 4);
            in_a = WIDTH'(next_beat); in_b = WIDTH'(next_beat); in_cin = 1'b0;
            @(negedge clk);
            acc = in_valid && in_ready;
            if (acc) accepts++;
            if (out_valid && out_sum !== 8'h02) unstable++;
            @(posedge clk); #1;
            if (acc) next_beat++;
        end
        @(negedge clk);
        checks++; if (accepts !== 2) begin failures++; $display("FAIL bp_accepts got=%0d exp=2", accepts); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready got=%0b exp=0", in_ready); end
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_out_valid got=%0b exp=1", out_valid); end
        checks++; if (out_sum !== 8'h02) begin failures++; $display("FAIL bp_hold_sum got=%02h exp=02", out_sum); end
        checks++; if (unstable !== 0) begin failures++; $display("FAIL bp_stable got=%0d exp=0", unstable); end
        @(posedge clk); #1;

        out_ready = 1'b1;
        for (int cyc = 0; cyc < 7; cyc++) begin
            in_valid = (next_beat <= 4);
            in_a = WIDTH'(next_beat); in_b = WIDTH'(next_beat);
            @(negedge clk);
            acc = in_valid && in_ready;
            if (out_valid && out_ready) begin
                if (n_out < 4) begin got[n_out] = out_sum; got_cyc[n_out] = cyc; end
                n_out++;
            end
            @(posedge clk); #1;
            if (acc) next_beat++;
        end
        in_valid = 1'b0;
        checks++; if (n_out !== 4) begin failures++; $display("FAIL bp_out_count got=%0d exp=4", n_out); end
        for (int i = 0; i < 4 && i < n_out; i++) begin
            exp_v = WIDTH'(2 * (i + 1));
            checks++; if (got[i] !== exp_v) begin failures++; $display("FAIL bp_seq[%0d] got=%02h exp=%02h", i, got[i], exp_v); end
            checks++; if (got_cyc[i] !== i) begin failures++; $display("FAIL bp_cycle[%0d] got=%0d exp=%0d", i, got_cyc[i], i); end
        end
        $display("test_backpressure accepts_stalled=%0d outputs=%0d", accepts, n_out);
    endtask

    task automatic test_reset_mid_flight();
        int stale = 0;
        logic [WIDTH-1:0] s; logic c; int lat;
        out_ready = 1'b0;
        in_valid = 1'b1; in_a = 8'h05; in_b = 8'h05; in_cin = 1'b0;
        @(posedge clk); #1;
        in_a = 8'h06; in_b = 8'h06;
        @(posedge clk); #1;
        in_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_out_valid got=%0b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL midrst_in_ready got=%0b exp=1", in_ready); end
        checks++; if (out_sum !== 8'h00) begin failures++; $display("FAIL midrst_out_sum got=%02h exp=00", out_sum); end
        @(posedge clk); #3; reset = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        @(posedge clk); #1;
        checks++; if (stale !== 0) begin failures++; $display("FAIL midrst_stale got=%0d exp=0", stale); end
        run_single(8'h21, 8'h10, 1'b0, s, c, lat);
        checks++; if ({c, s} !== 9'h031) begin failures++; $display("FAIL midrst_resume got=%03h exp=031", {c, s}); end
        $display("test_reset_mid_flight stale=%0d resume_sum=%02h", stale, s);
    endtask

    task automatic test_random();
        logic [WIDTH:0] exp_q [$];
        logic [WIDTH:0] exp_v;
        int n_acc = 0;
        int n_out = 0;
        for (int cyc = 0; cyc < 640; cyc++) begin
            if (cyc < 600) begin
                in_valid  = ($urandom_range(0, 3) != 0);
                out_ready = ($urandom_range(0, 3) != 0);
            end else begin
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end
            in_a = WIDTH'($urandom); in_b = WIDTH'($urandom); in_cin = 1'($urandom);
            @(negedge clk);
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_add(in_a, in_b, in_cin));
                n_acc++;
            end
            if (out_valid && out_ready) begin
                n_out++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL rand_unexpected got=%03h exp=none", {out_cout, out_sum});
                end else begin
                    exp_v = exp_q.pop_front();
                    if ({out_cout, out_sum} !== exp_v) begin
                        failures++; $display("FAIL rand_beat%0d got=%03h exp=%03h", n_out, {out_cout, out_sum}, exp_v);
                    end
                end
            end
            @(posedge clk); #1;
        end
        checks++; if (n_out !== n_acc) begin failures++; $display("FAIL rand_count got=%0d exp=%0d", n_out, n_acc); end
        $display("test_random accepted=%0d completed=%0d", n_acc, n_out);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_carry_in();
        test_backpressure();
        test_reset_mid_flight();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
